// File: rtl/axi_lite_interface_if.sv
// AXI4 bus bundle (AW/W/B/AR/R) connecting a master to the register-file bridge.
// Master/Slave modports give the direction of each channel signal from either side.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 10
);
    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]         w_strb;
    logic                      w_last;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_valid, input aw_ready,
        output w_data, w_strb, w_last, w_valid, input w_ready,
        input  b_id, b_resp, b_valid, output b_ready,
        output ar_id, ar_addr, ar_len, ar_valid, input ar_ready,
        input  r_id, r_data, r_resp, r_last, r_valid, output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_valid, output aw_ready,
        input  w_data, w_strb, w_last, w_valid, output w_ready,
        output b_id, b_resp, b_valid, input b_ready,
        input  ar_id, ar_addr, ar_len, ar_valid, output ar_ready,
        output r_id, r_data, r_resp, r_last, r_valid, input r_ready
    );
endinterface

// File: rtl/axi_lite_interface.sv
// Single-beat AXI slave bridging one transaction at a time onto a simple register-file strobe.
// Optional simulation checks (data width, burst length) enabled by AXI_LITE_INTERFACE_ASSERT_EN.
module axi_lite_interface #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 10
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    AXI_BUS.Slave                     slave,
    output logic [AXI_ADDR_WIDTH-1:0] address_o,
    output logic                      en_o,
    output logic                      we_o,
    output logic [63:0]               data_o,
    input  logic [63:0]               data_i
);
    localparam int unsigned REG_DATA_W = 64;
    localparam logic [1:0]  RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        WRITE  = 2'd2,
        SEND_B = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AXI_ID_WIDTH-1:0]   id_q, id_d;

    logic                      aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last;
    logic [AXI_ID_WIDTH-1:0]   b_id, r_id;
    logic [1:0]                b_resp, r_resp;
    logic [AXI_DATA_WIDTH-1:0] r_data;

    // Lengths, strobes and w_last carry no information for single full-word beats.
    logic unused_inputs;
    assign unused_inputs = ^{slave.aw_len, slave.ar_len, slave.w_strb, slave.w_last};

    // State, captured address and id.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
        end
    end

    // Next state and all channel/register-file outputs; reads take priority in IDLE.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        id_d      = id_q;
        aw_ready  = 1'b0;
        w_ready   = 1'b0;
        b_valid   = 1'b0;
        b_id      = '0;
        b_resp    = RESP_OKAY;
        ar_ready  = 1'b0;
        r_valid   = 1'b0;
        r_id      = '0;
        r_data    = '0;
        r_resp    = RESP_OKAY;
        r_last    = 1'b0;
        en_o      = 1'b0;
        we_o      = 1'b0;
        data_o    = '0;
        address_o = addr_q;

        unique case (state_q)
            IDLE: begin
                ar_ready = 1'b1;
                if (slave.ar_valid) begin
                    addr_d  = slave.ar_addr;
                    id_d    = slave.ar_id;
                    state_d = READ;
                end else begin
                    aw_ready = 1'b1;
                    if (slave.aw_valid) begin
                        addr_d  = slave.aw_addr;
                        id_d    = slave.aw_id;
                        state_d = WRITE;
                    end
                end
            end
            READ: begin
                en_o    = 1'b1;
                r_valid = 1'b1;
                r_data  = AXI_DATA_WIDTH'(data_i);
                r_last  = 1'b1;
                r_id    = id_q;
                if (slave.r_ready) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                w_ready = 1'b1;
                if (slave.w_valid) begin
                    en_o    = 1'b1;
                    we_o    = 1'b1;
                    data_o  = REG_DATA_W'(slave.w_data);
                    state_d = SEND_B;
                end
            end
            SEND_B: begin
                b_valid = 1'b1;
                b_id    = id_q;
                if (slave.b_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign slave.aw_ready = aw_ready;
    assign slave.w_ready  = w_ready;
    assign slave.b_valid  = b_valid;
    assign slave.b_id     = b_id;
    assign slave.b_resp   = b_resp;
    assign slave.ar_ready = ar_ready;
    assign slave.r_valid  = r_valid;
    assign slave.r_id     = r_id;
    assign slave.r_data   = r_data;
    assign slave.r_resp   = r_resp;
    assign slave.r_last   = r_last;

`ifdef AXI_LITE_INTERFACE_ASSERT_EN
    initial begin
        if (AXI_DATA_WIDTH != 64) begin
            $fatal(1, "axi_lite_interface: AXI_DATA_WIDTH=%0d, only 64 is supported", AXI_DATA_WIDTH);
        end
    end

    // Bursts would silently be truncated to one beat, so flag them at acceptance.
    always @(posedge clk_i) begin
        if (rst_ni && state_q == IDLE) begin
            if (slave.ar_valid && slave.ar_len != 8'd0) begin
                $error("axi_lite_interface: ar_len=%0d accepted, only single beats supported", slave.ar_len);
            end else if (slave.aw_valid && slave.aw_len != 8'd0) begin
                $error("axi_lite_interface: aw_len=%0d accepted, only single beats supported", slave.aw_len);
            end
        end
    end
`endif
endmodule

// File: tb/tb_axi_lite_interface.sv
// Directed self-checking bench for axi_lite_interface: reset, read, write, backpressure,
// read/write arbitration and reset during a write.
module tb_axi_lite_interface;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned IW = 10;

    logic          clk_i;
    logic          rst_ni;
    logic [AW-1:0] address_o;
    logic          en_o;
    logic          we_o;
    logic [63:0]   data_o;
    logic [63:0]   data_i;
    logic [63:0]   rd_value;

    int errors;
    int checks;

    AXI_BUS #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) bus ();

    axi_lite_interface #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .slave     (bus),
        .address_o (address_o),
        .en_o      (en_o),
        .we_o      (we_o),
        .data_o    (data_o),
        .data_i    (data_i)
    );

    // Register-file stand-in: read data only valid while a read strobe is up.
    assign data_i = (en_o && !we_o) ? rd_value : 64'h0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_valid = 1'b0;
        bus.w_data = '0; bus.w_strb = '1; bus.w_last = 1'b1; bus.w_valid = 1'b0;
        bus.b_ready = 1'b0;
        bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_valid = 1'b0;
        bus.r_ready = 1'b0;
        rd_value = 64'h0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        clear_inputs();
        #3;
        checks++; if (bus.ar_ready !== 1'b1) begin errors++; $display("FAIL rst_ar_ready got=%0b exp=1", bus.ar_ready); end
        checks++; if (bus.aw_ready !== 1'b1) begin errors++; $display("FAIL rst_aw_ready got=%0b exp=1", bus.aw_ready); end
        checks++; if ({bus.w_ready, bus.b_valid, bus.r_valid} !== 3'b000) begin errors++; $display("FAIL rst_valids got=%03b exp=000", {bus.w_ready, bus.b_valid, bus.r_valid}); end
        checks++; if ({en_o, we_o} !== 2'b00) begin errors++; $display("FAIL rst_en_we got=%02b exp=00", {en_o, we_o}); end
        checks++; if (address_o !== 64'h0) begin errors++; $display("FAIL rst_address got=%0h exp=0", address_o); end
        checks++; if (data_o !== 64'h0) begin errors++; $display("FAIL rst_data_o got=%0h exp=0", data_o); end
        step();
        step();
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_read();
        bus.ar_valid = 1'b1; bus.ar_addr = 64'hC00; bus.ar_id = 10'd5; rd_value = 64'h1234;
        #1;
        checks++; if ({bus.ar_ready, bus.aw_ready, en_o} !== 3'b100) begin errors++; $display("FAIL rd_accept got=%03b exp=100", {bus.ar_ready, bus.aw_ready, en_o}); end
        step();
        bus.ar_valid = 1'b0;
        #1;
        checks++; if (bus.r_valid !== 1'b1) begin errors++; $display("FAIL rd_r_valid got=%0b exp=1", bus.r_valid); end
        checks++; if (bus.r_data !== 64'h1234) begin errors++; $display("FAIL rd_r_data got=%0h exp=1234", bus.r_data); end
        checks++; if (bus.r_id !== 10'd5) begin errors++; $display("FAIL rd_r_id got=%0d exp=5", bus.r_id); end
        checks++; if ({bus.r_last, bus.r_resp} !== 3'b100) begin errors++; $display("FAIL rd_last_resp got=%03b exp=100", {bus.r_last, bus.r_resp}); end
        checks++; if ({en_o, we_o} !== 2'b10) begin errors++; $display("FAIL rd_en_we got=%02b exp=10", {en_o, we_o}); end
        checks++; if (address_o !== 64'hC00) begin errors++; $display("FAIL rd_address got=%0h exp=c00", address_o); end
        checks++; if ({bus.ar_ready, bus.aw_ready, bus.w_ready, bus.b_valid} !== 4'b0000) begin errors++; $display("FAIL rd_other_ready got=%04b exp=0000", {bus.ar_ready, bus.aw_ready, bus.w_ready, bus.b_valid}); end
        bus.r_ready = 1'b1;
        step();
        bus.r_ready = 1'b0;
        #1;
        checks++; if ({bus.r_valid, en_o, bus.ar_ready} !== 3'b001) begin errors++; $display("FAIL rd_back_idle got=%03b exp=001", {bus.r_valid, en_o, bus.ar_ready}); end
    endtask

    task automatic test_write();
        bus.aw_valid = 1'b1; bus.aw_addr = 64'h400; bus.aw_id = 10'd3;
        #1;
        checks++; if ({bus.ar_ready, bus.aw_ready, en_o} !== 3'b110) begin errors++; $display("FAIL wr_accept got=%03b exp=110", {bus.ar_ready, bus.aw_ready, en_o}); end
        step();
        bus.aw_valid = 1'b0;
        #1;
        checks++; if ({bus.w_ready, en_o, we_o, bus.aw_ready, bus.ar_ready} !== 5'b10000) begin errors++; $display("FAIL wr_wait_w got=%05b exp=10000", {bus.w_ready, en_o, we_o, bus.aw_ready, bus.ar_ready}); end
        step();
        checks++; if ({bus.w_ready, en_o} !== 2'b10) begin errors++; $display("FAIL wr_wait_w_hold got=%02b exp=10", {bus.w_ready, en_o}); end
        bus.w_valid = 1'b1; bus.w_data = 64'hDEAD_BEEF;
        #1;
        checks++; if ({en_o, we_o} !== 2'b11) begin errors++; $display("FAIL wr_strobe got=%02b exp=11", {en_o, we_o}); end
        checks++; if (data_o !== 64'hDEAD_BEEF) begin errors++; $display("FAIL wr_data_o got=%0h exp=deadbeef", data_o); end
        checks++; if (address_o !== 64'h400) begin errors++; $display("FAIL wr_address got=%0h exp=400", address_o); end
        checks++; if (bus.b_valid !== 1'b0) begin errors++; $display("FAIL wr_b_early got=%0b exp=0", bus.b_valid); end
        step();
        bus.w_valid = 1'b0;
        #1;
        checks++; if ({bus.b_valid, bus.b_resp, en_o, we_o, bus.w_ready} !== 6'b100000) begin errors++; $display("FAIL wr_b_phase got=%06b exp=100000", {bus.b_valid, bus.b_resp, en_o, we_o, bus.w_ready}); end
        checks++; if (bus.b_id !== 10'd3) begin errors++; $display("FAIL wr_b_id got=%0d exp=3", bus.b_id); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if ({bus.b_valid, bus.b_id, en_o} !== {1'b1, 10'd3, 1'b0}) begin errors++; $display("FAIL wr_b_stall cycle=%0d b_valid=%0b b_id=%0d en=%0b exp 1/3/0", i, bus.b_valid, bus.b_id, en_o); end
        end
        bus.b_ready = 1'b1;
        step();
        bus.b_ready = 1'b0;
        #1;
        checks++; if ({bus.b_valid, bus.aw_ready, bus.ar_ready} !== 3'b011) begin errors++; $display("FAIL wr_back_idle got=%03b exp=011", {bus.b_valid, bus.aw_ready, bus.ar_ready}); end
    endtask

    task automatic test_read_backpressure();
        bus.ar_valid = 1'b1; bus.ar_addr = 64'h18; bus.ar_id = 10'h2A5; rd_value = 64'hA5A5_0000_FFFF_0001;
        step();
        bus.ar_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if ({bus.r_valid, en_o, we_o} !== 3'b110 || bus.r_data !== 64'hA5A5_0000_FFFF_0001 || bus.r_id !== 10'h2A5) begin errors++; $display("FAIL rd_stall cycle=%0d r_valid=%0b en=%0b we=%0b r_data=%0h r_id=%0h exp 1/1/0/a5a50000ffff0001/2a5", i, bus.r_valid, en_o, we_o, bus.r_data, bus.r_id); end
            step();
        end
        // Read data tracks the register file combinationally while stalled.
        rd_value = 64'h0000_0000_0000_0077;
        #1;
        checks++; if (bus.r_data !== 64'h77) begin errors++; $display("FAIL rd_stall_follow got=%0h exp=77", bus.r_data); end
        bus.r_ready = 1'b1;
        step();
        bus.r_ready = 1'b0;
        #1;
        checks++; if ({bus.r_valid, en_o, bus.ar_ready, bus.aw_ready} !== 4'b0011) begin errors++; $display("FAIL rd_stall_release got=%04b exp=0011", {bus.r_valid, en_o, bus.ar_ready, bus.aw_ready}); end
    endtask

    task automatic test_back_to_back();
        bus.ar_valid = 1'b1; bus.ar_addr = 64'h100; bus.ar_id = 10'd7; rd_value = 64'h55;
        bus.aw_valid = 1'b1; bus.aw_addr = 64'h200; bus.aw_id = 10'd9;
        #1;
        checks++; if ({bus.ar_ready, bus.aw_ready} !== 2'b10) begin errors++; $display("FAIL arb_ready got=%02b exp=10", {bus.ar_ready, bus.aw_ready}); end
        step();
        bus.ar_valid = 1'b0;
        #1;
        checks++; if ({bus.r_valid, bus.aw_ready} !== 2'b10 || bus.r_id !== 10'd7 || address_o !== 64'h100) begin errors++; $display("FAIL arb_read_first r_valid=%0b aw_ready=%0b r_id=%0d addr=%0h exp 1/0/7/100", bus.r_valid, bus.aw_ready, bus.r_id, address_o); end
        bus.r_ready = 1'b1;
        step();
        bus.r_ready = 1'b0;
        #1;
        checks++; if ({bus.r_valid, bus.aw_ready, en_o} !== 3'b010) begin errors++; $display("FAIL arb_aw_after_r got=%03b exp=010", {bus.r_valid, bus.aw_ready, en_o}); end
        step();
        bus.aw_valid = 1'b0;
        bus.w_valid = 1'b1; bus.w_data = 64'h0123_4567_89AB_CDEF;
        #1;
        checks++; if ({en_o, we_o} !== 2'b11 || address_o !== 64'h200 || data_o !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL arb_write en=%0b we=%0b addr=%0h data=%0h exp 1/1/200/123456789abcdef", en_o, we_o, address_o, data_o); end
        step();
        bus.w_valid = 1'b0;
        bus.b_ready = 1'b1;
        #1;
        checks++; if (bus.b_valid !== 1'b1 || bus.b_id !== 10'd9) begin errors++; $display("FAIL arb_b b_valid=%0b b_id=%0d exp 1/9", bus.b_valid, bus.b_id); end
        step();
        bus.b_ready = 1'b0;
        #1;
        checks++; if ({bus.b_valid, bus.ar_ready, bus.aw_ready} !== 3'b011) begin errors++; $display("FAIL arb_idle got=%03b exp=011", {bus.b_valid, bus.ar_ready, bus.aw_ready}); end
    endtask

    task automatic test_reset_in_write();
        bus.aw_valid = 1'b1; bus.aw_addr = 64'h800; bus.aw_id = 10'd12;
        step();
        bus.aw_valid = 1'b0;
        #1;
        checks++; if (bus.w_ready !== 1'b1) begin errors++; $display("FAIL rstw_in_write got=%0b exp=1", bus.w_ready); end
        bus.w_valid = 1'b1; bus.w_data = 64'hFFFF;
        rst_ni = 1'b0;
        #1;
        checks++; if ({en_o, we_o, bus.w_ready, bus.b_valid} !== 4'b0000) begin errors++; $display("FAIL rstw_abort got=%04b exp=0000", {en_o, we_o, bus.w_ready, bus.b_valid}); end
        checks++; if ({bus.ar_ready, bus.aw_ready} !== 2'b11 || address_o !== 64'h0) begin errors++; $display("FAIL rstw_idle ar=%0b aw=%0b addr=%0h exp 1/1/0", bus.ar_ready, bus.aw_ready, address_o); end
        step();
        bus.w_valid = 1'b0;
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if ({bus.b_valid, bus.r_valid, en_o, bus.w_ready} !== 4'b0000) begin errors++; $display("FAIL rstw_after cycle=%0d got=%04b exp=0000", i, {bus.b_valid, bus.r_valid, en_o, bus.w_ready}); end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_read();
        step();
        test_write();
        step();
        test_read_backpressure();
        step();
        test_back_to_back();
        step();
        test_reset_in_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi_lite_interface.md
AXI_LITE_INTERFACE -- requirements
Module: axi_lite_interface

Interface
- REQ-001: Parameter AXI_ADDR_WIDTH SHALL have default 64 and set the address width.
- REQ-002: Parameter AXI_DATA_WIDTH SHALL have default 64 and set the data width; only 64 is supported.
- REQ-003: Parameter AXI_ID_WIDTH SHALL have default 10 and set the transaction ID width.
- REQ-004: Port clk_i SHALL be an input, 1 bit wide, and is the single clock; all logic is on its rising edge.
- REQ-005: Port rst_ni SHALL be an input, 1 bit wide, and is the asynchronous active-low reset.
- REQ-006: Port slave SHALL be an AXI_BUS.Slave interface port carrying the AW/W/B/AR/R channels with id, addr, data, strb, resp, last, valid and ready signals.
- REQ-007: Port address_o SHALL be an output, AXI_ADDR_WIDTH wide, carrying the captured transaction address to the register file.
- REQ-008: Port en_o SHALL be an output, 1 bit wide, and is the register access strobe.
- REQ-009: Port we_o SHALL be an output, 1 bit wide; 1 means write and 0 means read, and it is valid only while en_o=1.
- REQ-010: Port data_o SHALL be an output, 64 bits wide, carrying write data to the register file.
- REQ-011: Port data_i SHALL be an input, 64 bits wide, carrying read data from the register file; it is combinational in address_o, en_o and we_o.

Function
- REQ-012: The block SHALL implement a four-state machine with states IDLE, READ, WRITE and SEND_B.
- REQ-013: In IDLE, ar_ready=1 SHALL hold. When ar_valid=1, the block SHALL capture ar_addr and ar_id and go to READ.
- REQ-014: In IDLE with ar_valid=0, aw_ready=1 SHALL hold. When aw_valid=1, the block SHALL capture aw_addr and aw_id and go to WRITE.
- REQ-015: When ar_valid and aw_valid are both high in IDLE, the read SHALL win; aw_ready=0 in that cycle.
- REQ-016: In READ, the outputs SHALL be en_o=1, we_o=0, address_o=captured address, r_valid=1, r_data=data_i, r_resp=OKAY (2'b00), r_last=1 and r_id=captured id.
- REQ-017: In READ, r_ready=1 SHALL return the machine to IDLE; otherwise it stays in READ with the outputs held stable.
- REQ-018: In WRITE, w_ready=1 SHALL hold. When w_valid=1, the outputs SHALL be en_o=1, we_o=1 and data_o=w_data for exactly that cycle, then the machine goes to SEND_B.
- REQ-019: In SEND_B, the outputs SHALL be b_valid=1, b_resp=OKAY and b_id=captured id. b_ready=1 returns the machine to IDLE.
- REQ-020: Outside READ and the accepted-W cycle, en_o=0 and we_o=0 SHALL hold; data_o and address_o are don't-care when en_o=0.
- REQ-021: Only single-beat transfers SHALL be supported; ar_len/aw_len are ignored and exactly one W beat is consumed per write.
- REQ-022: w_strb SHALL be ignored; every write updates the full 64-bit word.
- REQ-023: All AXI responses SHALL be OKAY; unmapped addresses are handled by the register file.
- REQ-024: Every ready/valid output not named above SHALL be 0 in each state; at most one transaction is outstanding at any time.
- REQ-025: A new request SHALL be accepted no earlier than the cycle after IDLE is re-entered. Read throughput is at most one transaction per 2 cycles; write throughput is at most one per 3 cycles.

Reset
- REQ-026: Asserting rst_ni=0 SHALL, asynchronously, force the state to IDLE and clear the captured address, captured id and all outputs to 0, except that ar_ready=1 and aw_ready=1 as IDLE dictates.
- REQ-027: Reset asserted mid-transaction SHALL abort that transaction with no B or R response and no further en_o pulse.

Configuration
- REQ-028: With macro AXI_LITE_INTERFACE_ASSERT_EN defined, simulation SHALL fatally error if AXI_DATA_WIDTH != 64 at time 0, and SHALL flag an error on any accepted ar_len or aw_len != 0.
- REQ-029: Without AXI_LITE_INTERFACE_ASSERT_EN, no checks SHALL be compiled in and behaviour is otherwise identical.

Verification
- REQ-030: Read: ar_addr=0xC00, id=5 with data_i=0x1234 -> one cycle later r_valid=1, r_data=0x1234, r_id=5, r_last=1, resp=OKAY, en_o=1, we_o=0.
- REQ-031: Write: aw_addr=0x400, id=3, then w_data=0xDEAD_BEEF -> a single en_o/we_o pulse with data_o=0xDEAD_BEEF and address_o=0x400, then b_valid=1 with b_id=3.
- REQ-032: Backpressure: r_ready held 0 for 5 cycles -> r_valid, r_data and en_o stay stable; release -> IDLE. Same check for b_ready.
- REQ-033: Simultaneous ar_valid and aw_valid in IDLE -> read served first; write accepted after the R handshake completes.
- REQ-034: Reset asserted in WRITE -> IDLE immediately, no b_valid, and en_o stays 0.
